// File: rtl/frame_ram_writer_if.sv
// Pixel stream handshake plus frame RAM write port, bundled so the writer
// and its environment see one bus.
interface frame_ram_writer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] wraddress;
    logic [7:0]  data;
    logic        wren;

    modport slave (
        input  in_data, in_valid,
        output in_ready, wraddress, data, wren
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, wraddress, data, wren
    );
endinterface

// File: rtl/frame_ram_writer.sv
// Streams one grayscale frame (1 byte/pixel, row-major) into the frame RAM
// write port, starting at BASE_ADDRESS, and reports done after the last pixel.
module frame_ram_writer #(
    parameter logic [17:0] BASE_ADDRESS = 18'h10,
    parameter int          IMG_WIDTH    = 400,
    parameter int          IMG_HEIGHT   = 433
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    frame_ram_writer_if.slave    bus,
    output logic [9:0]           cur_x,
    output logic [9:0]           cur_y,
    output logic                 busy,
    output logic                 done
);
    localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state;
    logic [17:0] ptr;
    logic        accept;
    logic        last_px;

    assign bus.in_ready = (state == WRITE);
    assign accept       = bus.in_valid && (state == WRITE);
    assign last_px      = (cur_x == X_LAST) && (cur_y == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= BASE_ADDRESS;
            cur_x         <= '0;
            cur_y         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.wren      <= 1'b0;
            bus.wraddress <= BASE_ADDRESS;
            bus.data      <= '0;
        end else begin
            bus.wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= WRITE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        ptr   <= BASE_ADDRESS;
                        cur_x <= '0;
                        cur_y <= '0;
                    end
                end
                WRITE: begin
                    // abort wins over a same-cycle accept: that byte is never written
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= BASE_ADDRESS;
                        cur_x <= '0;
                        cur_y <= '0;
                    end else if (accept) begin
                        bus.wren      <= 1'b1;
                        bus.data      <= bus.in_data;
                        bus.wraddress <= ptr;
                        if (last_px) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            ptr   <= BASE_ADDRESS;
                            cur_x <= '0;
                            cur_y <= '0;
                        end else begin
                            ptr <= ptr + 18'd1;
                            if (cur_x == X_LAST) begin
                                cur_x <= '0;
                                cur_y <= cur_y + 10'd1;
                            end else begin
                                cur_x <= cur_x + 10'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state <= WRITE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        ptr   <= BASE_ADDRESS;
                        cur_x <= '0;
                        cur_y <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/frame_ram_writer.md
Name: frame_ram_writer

Overview:
- Fills the frame RAM that the VGA scan-out path reads: 1 byte per pixel, grayscale, row-major, starting at BASE_ADDRESS.
- Accepts a byte stream from the image-processing or load path through a valid/ready handshake.
- Writes exactly IMG_WIDTH*IMG_HEIGHT bytes, then signals done.
- Drives the RAM write port (wraddress/data/wren) while the display side owns the read port.

Parameters:
- BASE_ADDRESS, 18'h10, RAM address of pixel (0,0).
- IMG_WIDTH, 400, pixels per row.
- IMG_HEIGHT, 433, rows per frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame load.
- abort  input  1  one-cycle pulse; cancels the current load.
- in_data  input  8  pixel byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  writer accepts in_data this cycle.
- wraddress  output  18  RAM write address.
- data  output  8  RAM write data.
- wren  output  1  RAM write enable.
- cur_x  output  10  column of the next pixel to accept.
- cur_y  output  10  row of the next pixel to accept.
- busy  output  1  high in WRITE.
- done  output  1  high in DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; wren=0, wraddress=BASE_ADDRESS, data=0.
  - cur_x=0, cur_y=0, busy=0, done=0, in_ready=0.
- States:
  - IDLE: start -> WRITE. Counters and address pointer load 0/0/BASE_ADDRESS.
  - WRITE: last pixel accepted -> DONE. abort -> IDLE.
  - DONE: start -> WRITE with counters reloaded. abort -> IDLE.
- in_ready is combinational: (state==WRITE). Accept = in_valid & in_ready.
- On accept (registered, 1-cycle latency):
  - Next cycle: wren=1, data=in_data, wraddress=pointer.
  - The pointer then increments by 1.
  - Without an accept, wren=0 next cycle; wraddress/data hold their last values.
- Counter updates on accept:
  - cur_x increments.
  - At cur_x==IMG_WIDTH-1: cur_x returns to 0 and cur_y increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1): the transition to DONE happens in the same cycle. cur_x and cur_y go to 0, and the pointer goes back to BASE_ADDRESS.
- Last write address is BASE_ADDRESS + IMG_WIDTH*IMG_HEIGHT - 1. With defaults this is 18'h2A49F. The 18-bit address never wraps for legal parameters; it is not checked in RTL.
- One write per accepted byte, one accept per cycle max. Back-to-back valid gives continuous wren.
- Gaps in in_valid stall the writer; no bytes are dropped or duplicated.
- start while in WRITE is ignored.
- abort has priority over start and over accept in the same cycle:
  - no write is issued for that byte;
  - the state goes to IDLE and counters reset;
  - RAM contents already written are left as-is.
- start and abort in the same cycle in IDLE: remain in IDLE.
- The last-pixel write is issued in the first DONE cycle. done rises in the same cycle as that final wren.
- busy=(state==WRITE) and done=(state==DONE) are registered state decodes.
- Async reset mid-frame: immediate return to reset values; a pending write is cancelled (wren=0).

Test Plan:
- Use IMG_WIDTH=4, IMG_HEIGHT=3, BASE_ADDRESS=0x10.
- Full-rate load: reset, start, 12 bytes 0x00..0x0B with continuous in_valid -> wren high 12 consecutive cycles, addresses 0x10..0x1B with matching data; done=1 and busy=0 on the cycle of the 0x1B write; in_ready=0 afterwards.
- Row wrap: after 4 accepts -> cur_x=0, cur_y=1; after 8 accepts -> cur_y=2; after 12 -> cur_x=0, cur_y=0.
- Stalled stream: in_valid pattern 1,0,0,1,1,0,1... over 12 bytes -> exactly 12 wren pulses, addresses strictly sequential 0x10..0x1B, no duplicates, wren=0 on idle cycles.
- Abort mid-frame: abort on the same cycle as the 6th accept -> only 5 writes (0x10..0x14), state IDLE, in_ready=0. A new start then writes from 0x10 again.
- Restart from DONE: after a complete load, start -> busy=1, first write at 0x10. start pulsed during WRITE has no effect on address sequence.
- Async reset: assert rst mid-cycle during the 7th byte -> wren, busy, done and in_ready drop to 0 immediately, wraddress=0x10, cur_x=cur_y=0; no write is issued after release until start.
